// File: rtl/fpu_rr_arbiter_if.sv
// Requester-side bus of fpu_rr_arbiter: per-requester request and response
// handshakes, slice i of every bus belongs to requester i.
interface fpu_rr_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ-1:0][1:0]  req_funct;
  logic [N_REQ-1:0][31:0] req_a;
  logic [N_REQ-1:0][31:0] req_b;
  logic [N_REQ-1:0]       rsp_valid;
  logic [N_REQ-1:0]       rsp_ready;
  logic [31:0]            rsp_data;
  logic                   rsp_err;

  modport master (
    output req_valid, req_funct, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_funct, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/fpu_rr_arbiter.sv
// Round-robin sharing of one fpu between N_REQ requesters, one operation in flight.
// Optional WAIT watchdog: define FPU_ARB_TIMEOUT_EN (aborts with qNaN, rsp_err=1).
module fpu_rr_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic        i_clk,
  input  logic        i_rst,
  fpu_rr_arbiter_if.slave io,
  output logic [1:0]  o_fpu_funct,
  output logic [31:0] o_fpu_a,
  output logic [31:0] o_fpu_b,
  input  logic [31:0] i_fpu_o,
  input  logic        i_fpu_finish,
  output logic        o_busy
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_t;

  state_t      r_state;
  logic [IW-1:0] r_g;
  logic [IW-1:0] r_ptr;
  logic        r_finish_q;
  logic [1:0]  r_fpu_funct;
  logic [31:0] r_fpu_a;
  logic [31:0] r_fpu_b;
  logic [31:0] r_rsp_data;

  logic [IW-1:0] w_win;
  logic        w_any;
  logic        w_done;
  logic        w_rsp_hs;

  // Highest offset first so the nearest set bit after the pointer wins last.
  always_comb begin
    logic [IW-1:0] idx;
    idx   = '0;
    w_win = '0;
    w_any = 1'b0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = IW'((int'(r_ptr) + k) % N_REQ);
      if (io.req_valid[idx]) begin
        w_win = idx;
        w_any = 1'b1;
      end
    end
  end

  assign w_done   = i_fpu_finish & ~r_finish_q;
  assign w_rsp_hs = (r_state == S_RESP) & io.rsp_ready[r_g];

  assign io.req_ready = (r_state == S_IDLE && w_any) ? (N_REQ'(1) << w_win) : '0;
  assign io.rsp_valid = (r_state == S_RESP) ? (N_REQ'(1) << r_g) : '0;
  assign io.rsp_data  = r_rsp_data;
  assign o_fpu_funct  = r_fpu_funct;
  assign o_fpu_a      = r_fpu_a;
  assign o_fpu_b      = r_fpu_b;
  assign o_busy       = (r_state != S_IDLE);

`ifdef FPU_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_tcnt;
  logic          r_rsp_err;
  assign io.rsp_err = r_rsp_err;
`else
  localparam int unused_timeout = TIMEOUT;
  assign io.rsp_err = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_g         <= '0;
      r_ptr       <= IW'(N_REQ - 1);
      r_finish_q  <= 1'b0;
      r_fpu_funct <= '0;
      r_fpu_a     <= '0;
      r_fpu_b     <= '0;
      r_rsp_data  <= '0;
`ifdef FPU_ARB_TIMEOUT_EN
      r_tcnt      <= '0;
      r_rsp_err   <= 1'b0;
`endif
    end else begin
      r_finish_q <= i_fpu_finish;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_g         <= w_win;
            r_fpu_funct <= io.req_funct[w_win];
            r_fpu_a     <= io.req_a[w_win];
            r_fpu_b     <= io.req_b[w_win];
            r_state     <= S_WAIT;
`ifdef FPU_ARB_TIMEOUT_EN
            r_tcnt      <= '0;
`endif
          end
        end
        S_WAIT: begin
          // A finish already high at launch has r_finish_q set, so only a fresh rise completes.
          if (w_done) begin
            r_rsp_data <= i_fpu_o;
            r_state    <= S_RESP;
`ifdef FPU_ARB_TIMEOUT_EN
            r_rsp_err  <= 1'b0;
          end else if (r_tcnt == TW'(TIMEOUT - 1)) begin
            r_rsp_data <= 32'h7FC0_0000;
            r_rsp_err  <= 1'b1;
            r_state    <= S_RESP;
          end else begin
            r_tcnt     <= r_tcnt + 1'b1;
`endif
          end
        end
        S_RESP: begin
          if (w_rsp_hs) begin
            r_ptr   <= r_g;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fpu_rr_arbiter.sv
// Directed bench for fpu_rr_arbiter: table of back-to-back operations plus
// stale-finish, backpressure, reset-mid-WAIT and (if enabled) timeout sequences.
module tb_fpu_rr_arbiter;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  fpu_funct;
  logic [31:0] fpu_a, fpu_b;
  logic [31:0] fpu_o = '0;
  logic        fpu_finish = 1'b0;
  logic        busy;
  int          n_vec = 0;
  int          n_err = 0;

  fpu_rr_arbiter_if #(.N_REQ(N)) bus ();

  fpu_rr_arbiter #(.N_REQ(N), .TIMEOUT(8)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .io          (bus.slave),
    .o_fpu_funct (fpu_funct),
    .o_fpu_a     (fpu_a),
    .o_fpu_b     (fpu_b),
    .i_fpu_o     (fpu_o),
    .i_fpu_finish(fpu_finish),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  valid;
    int          lat;
    logic [31:0] res;
    logic [3:0]  gnt;
    logic [1:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
  } vec_t;

  vec_t vt [9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Entered and left at negedge+1 with the arbiter in IDLE.
  task automatic run_vec(input int id, input vec_t v);
    bus.req_valid = v.valid;
    #1;
    chk($sformatf("v%0d req_ready", id), 32'(bus.req_ready), 32'(v.gnt));
    chk($sformatf("v%0d busy_idle", id), 32'(busy), 32'd0);
    cyc(); #1;
    chk($sformatf("v%0d busy", id), 32'(busy), 32'd1);
    chk($sformatf("v%0d ready_wait", id), 32'(bus.req_ready), 32'd0);
    chk($sformatf("v%0d fpu_funct", id), 32'(fpu_funct), 32'(v.funct));
    for (int i = 0; i < v.lat; i++) begin
      cyc(); #1;
      chk($sformatf("v%0d fpu_a", id), fpu_a, v.a);
      chk($sformatf("v%0d fpu_b", id), fpu_b, v.b);
      chk($sformatf("v%0d rsp_early", id), 32'(bus.rsp_valid), 32'd0);
    end
    cyc();
    fpu_finish = 1'b1;
    fpu_o      = v.res;
    cyc();
    fpu_finish = 1'b0;
    fpu_o      = 32'hBAD0_BAD0;
    #1;
    chk($sformatf("v%0d rsp_valid", id), 32'(bus.rsp_valid), 32'(v.gnt));
    chk($sformatf("v%0d rsp_data", id), bus.rsp_data, v.res);
    chk($sformatf("v%0d rsp_err", id), 32'(bus.rsp_err), 32'd0);
    chk($sformatf("v%0d ready_resp", id), 32'(bus.req_ready), 32'd0);
    bus.rsp_ready = v.gnt;
    cyc();
    bus.rsp_ready = '0;
    #1;
    chk($sformatf("v%0d rsp_clr", id), 32'(bus.rsp_valid), 32'd0);
    chk($sformatf("v%0d busy_clr", id), 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = '0;
    bus.rsp_ready = '0;
    bus.req_funct[0] = 2'd1; bus.req_a[0] = 32'hAAAA_0000; bus.req_b[0] = 32'h0000_000A;
    bus.req_funct[1] = 2'd0; bus.req_a[1] = 32'h3F80_0000; bus.req_b[1] = 32'h4000_0000;
    bus.req_funct[2] = 2'd2; bus.req_a[2] = 32'hC000_0000; bus.req_b[2] = 32'h4080_0000;
    bus.req_funct[3] = 2'd3; bus.req_a[3] = 32'h4120_0000; bus.req_b[3] = 32'h3F00_0000;

    vt[0] = '{4'b1111, 2, 32'h1111_0000, 4'b0001, 2'd1, 32'hAAAA_0000, 32'h0000_000A};
    vt[1] = '{4'b1111, 1, 32'h2222_0001, 4'b0010, 2'd0, 32'h3F80_0000, 32'h4000_0000};
    vt[2] = '{4'b1111, 3, 32'h3333_0002, 4'b0100, 2'd2, 32'hC000_0000, 32'h4080_0000};
    vt[3] = '{4'b1111, 1, 32'h4444_0003, 4'b1000, 2'd3, 32'h4120_0000, 32'h3F00_0000};
    vt[4] = '{4'b1111, 2, 32'h5555_0000, 4'b0001, 2'd1, 32'hAAAA_0000, 32'h0000_000A};
    vt[5] = '{4'b0010, 5, 32'h4040_0000, 4'b0010, 2'd0, 32'h3F80_0000, 32'h4000_0000};
    vt[6] = '{4'b1001, 1, 32'h6666_0003, 4'b1000, 2'd3, 32'h4120_0000, 32'h3F00_0000};
    vt[7] = '{4'b1001, 2, 32'h7777_0000, 4'b0001, 2'd1, 32'hAAAA_0000, 32'h0000_000A};
    vt[8] = '{4'b0100, 1, 32'h8888_0002, 4'b0100, 2'd2, 32'hC000_0000, 32'h4080_0000};

    // reset state
    repeat (2) cyc();
    #1;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst fpu_a", fpu_a, 32'd0);
    chk("rst fpu_b", fpu_b, 32'd0);
    chk("rst rsp_data", bus.rsp_data, 32'd0);
    chk("rst rsp_err", 32'(bus.rsp_err), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) run_vec(i, vt[i]);

    // stale finish: high through launch, drops, re-rises
    bus.req_valid = 4'b0001;
    fpu_finish    = 1'b1;
    fpu_o         = 32'hDEAD_0001;
    #1;
    chk("stale req_ready", 32'(bus.req_ready), 32'b0001);
    cyc(); #1;
    chk("stale busy", 32'(busy), 32'd1);
    chk("stale rsp0", 32'(bus.rsp_valid), 32'd0);
    bus.req_valid = '0;
    fpu_o = 32'hDEAD_0002;
    cyc(); #1;
    chk("stale rsp1", 32'(bus.rsp_valid), 32'd0);
    fpu_finish = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc(); #1;
      chk("stale low rsp", 32'(bus.rsp_valid), 32'd0);
      chk("stale low busy", 32'(busy), 32'd1);
    end
    cyc();
    fpu_finish = 1'b1;
    fpu_o      = 32'h3F00_BEEF;
    cyc();
    fpu_finish = 1'b0;
    #1;
    chk("stale rsp_valid", 32'(bus.rsp_valid), 32'b0001);
    chk("stale rsp_data", bus.rsp_data, 32'h3F00_BEEF);
    bus.rsp_ready = 4'b0001;
    cyc();
    bus.rsp_ready = '0;
    #1;
    chk("stale done", 32'(busy), 32'd0);

    // backpressure on requester 2 while requester 0 waits
    bus.req_valid = 4'b0100;
    #1;
    chk("bp req_ready", 32'(bus.req_ready), 32'b0100);
    cyc(); #1;
    chk("bp fpu_funct", 32'(fpu_funct), 32'd2);
    fpu_finish    = 1'b1;
    fpu_o         = 32'h1234_5678;
    bus.req_valid = 4'b0001;
    cyc();
    fpu_finish    = 1'b0;
    bus.rsp_ready = 4'b1011;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("bp rsp_valid", 32'(bus.rsp_valid), 32'b0100);
      chk("bp rsp_data", bus.rsp_data, 32'h1234_5678);
      chk("bp req_ready", 32'(bus.req_ready), 32'd0);
      cyc();
    end
    bus.rsp_ready = 4'b0100;
    cyc();
    bus.rsp_ready = '0;
    #1;
    chk("bp busy_clr", 32'(busy), 32'd0);
    chk("bp next grant", 32'(bus.req_ready), 32'b0001);
    cyc(); #1;
    chk("bp g0 busy", 32'(busy), 32'd1);
    chk("bp g0 fpu_a", fpu_a, 32'hAAAA_0000);
    bus.req_valid = '0;

    // reset while requester 0 is in WAIT
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    chk("mrst busy", 32'(busy), 32'd0);
    chk("mrst rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("mrst req_ready", 32'(bus.req_ready), 32'd0);
    chk("mrst fpu_funct", 32'(fpu_funct), 32'd0);
    chk("mrst fpu_a", fpu_a, 32'd0);
    chk("mrst fpu_b", fpu_b, 32'd0);
    chk("mrst rsp_data", bus.rsp_data, 32'd0);
    chk("mrst rsp_err", 32'(bus.rsp_err), 32'd0);
    fpu_finish = 1'b1;
    fpu_o      = 32'hCAFE_F00D;
    cyc();
    fpu_finish = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(); #1;
      chk("mrst no rsp", 32'(bus.rsp_valid), 32'd0);
      chk("mrst idle", 32'(busy), 32'd0);
    end
    bus.req_valid = 4'b1111;
    #1;
    chk("mrst grant0", 32'(bus.req_ready), 32'b0001);

`ifdef FPU_ARB_TIMEOUT_EN
    // finish never rises: abort after 8 WAIT cycles
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (i == 0) bus.req_valid = '0;
      #1;
      chk("to wait rsp", 32'(bus.rsp_valid), 32'd0);
      chk("to wait busy", 32'(busy), 32'd1);
    end
    cyc(); #1;
    chk("to rsp_valid", 32'(bus.rsp_valid), 32'b0001);
    chk("to rsp_data", bus.rsp_data, 32'h7FC0_0000);
    chk("to rsp_err", 32'(bus.rsp_err), 32'd1);
    fpu_finish = 1'b1;
    fpu_o      = 32'h0000_0001;
    cyc();
    fpu_finish = 1'b0;
    #1;
    chk("to late data", bus.rsp_data, 32'h7FC0_0000);
    bus.rsp_ready = 4'b0001;
    cyc();
    bus.rsp_ready = '0;
    #1;
    chk("to done", 32'(busy), 32'd0);
`else
    cyc();
    bus.req_valid = '0;
    fpu_finish    = 1'b1;
    fpu_o         = 32'h0BAD_CAFE;
    cyc();
    fpu_finish = 1'b0;
    #1;
    chk("end rsp_valid", 32'(bus.rsp_valid), 32'b0001);
    chk("end rsp_data", bus.rsp_data, 32'h0BAD_CAFE);
    chk("end rsp_err", 32'(bus.rsp_err), 32'd0);
    bus.rsp_ready = 4'b0001;
    cyc();
    bus.rsp_ready = '0;
    #1;
    chk("end done", 32'(busy), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
